dbg_dump_sequencer: RTL and testbench

- Frame-level controller for the debug dump path to the JTAG UART.
- On a START pulse it walks the debug sources in a fixed order: register file words, memory words, PC, instruction, then clock count.
- It drives the source select and index, captures each 40-bit word and serialises it LSB-byte-first to the UART write port with a valid/ready handshake.
- The frame is wrapped with a start-of-frame byte and an 8-bit checksum. This replaces free-running divided-clock sequencing with a deterministic, back-pressure-aware scheduler.

---
 rtl/dbg_dump_sequencer.sv | 87 ++++++++
 tb/tb_dbg_dump_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dbg_dump_sequencer.sv
// dbg_dump_sequencer: walks debug sources and streams an SOF/data/checksum frame to the UART write port
module dbg_dump_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int NUM_MEM = 8,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic        CLK_50,
  input  logic        RESET,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  SEL,
  output logic [4:0]  IDX,
  input  logic [39:0] R_IN,
  input  logic [39:0] M_IN,
  input  logic [39:0] PC_IN,
  input  logic [39:0] INS_IN,
  input  logic [39:0] CLK_IN,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY
);
  localparam logic [2:0] IDLE = 3'd0, SOF = 3'd1, ADDR = 3'd2, FETCH = 3'd3, SEND = 3'd4, CSUM = 3'd5, FIN = 3'd6;
  localparam logic [4:0] last_reg = 5'(NUM_REGS - 1);
  localparam logic [4:0] last_mem = 5'(NUM_MEM - 1);
  logic [2:0] state;
  logic [39:0] hold;
  logic [2:0] k;
  logic [7:0] csum;
  logic [39:0] src;
  assign src = SEL == 3'd0 ? R_IN : SEL == 3'd1 ? M_IN : SEL == 3'd2 ? PC_IN : SEL == 3'd3 ? INS_IN : CLK_IN;
  assign BUSY = state != IDLE && state != FIN;
  assign DONE = state == FIN;
  assign TX_VALID = state == SOF || state == SEND || state == CSUM;
  assign TX_DATA = state == SOF ? SOF_BYTE : state == SEND ? hold[{k, 3'b000} +: 8] : state == CSUM ? csum : 8'h00;
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state <= IDLE;
      SEL <= 3'd0;
      IDX <= 5'd0;
      csum <= 8'h00;
      k <= 3'd0;
      hold <= 40'd0;
    end else begin
      case (state)
        IDLE: if (START) begin
          state <= SOF;
          csum <= 8'h00;
        end
        SOF: if (TX_READY) begin
          state <= ADDR;
          SEL <= 3'd0;
          IDX <= 5'd0;
        end
        ADDR: state <= FETCH;
        FETCH: begin
          hold <= src;
          k <= 3'd0;
          state <= SEND;
        end
        SEND: if (TX_READY) begin
          csum <= csum + TX_DATA;
          k <= k + 3'd1;
          if (k == 3'd4) begin
            state <= SEL == 3'd4 ? CSUM : ADDR;
            // index rolls into the next source once the current one is exhausted
            if (SEL == 3'd0) begin
              SEL <= IDX == last_reg ? 3'd1 : 3'd0;
              IDX <= IDX == last_reg ? 5'd0 : IDX + 5'd1;
            end else if (SEL == 3'd1) begin
              SEL <= IDX == last_mem ? 3'd2 : 3'd1;
              IDX <= IDX == last_mem ? 5'd0 : IDX + 5'd1;
            end else if (SEL != 3'd4) begin
              SEL <= SEL + 3'd1;
            end
          end
        end
        CSUM: if (TX_READY) begin
          state <= FIN;
          SEL <= 3'd0;
          IDX <= 5'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_dump_sequencer.sv
// tb_dbg_dump_sequencer: directed frame checks with reset, index walk, back-pressure and abort cases
module tb_dbg_dump_sequencer;
  localparam logic [39:0] PAT = 40'h0102030405;
  logic CLK_50 = 1'b0, RESET = 1'b1, START = 1'b0, TX_READY = 1'b1, walk = 1'b0;
  logic BUSY, DONE, TX_VALID;
  logic [2:0] SEL;
  logic [4:0] IDX, idx_q;
  logic [7:0] TX_DATA;
  logic [39:0] R_IN;
  int tests = 0, fails = 0;
  logic [7:0] got[$], exp_q[$];
  int sel_log[$], idx_log[$];
  int busy_cnt, done_cnt, stab_err, idx_err, tail_err, bad;

  always #5 CLK_50 = ~CLK_50;
  always @(posedge CLK_50) idx_q <= IDX;
  assign R_IN = walk ? {35'd0, idx_q} : PAT;

  dbg_dump_sequencer dut (
    .CLK_50(CLK_50), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE),
    .SEL(SEL), .IDX(IDX), .R_IN(R_IN), .M_IN(PAT), .PC_IN(PAT), .INS_IN(PAT),
    .CLK_IN(PAT), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input bit w);
    int s;
    logic [7:0] b;
    s = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int wd = 0; wd < 27; wd++)
      for (int i = 0; i < 5; i++) begin
        b = (w && wd < 16) ? (i == 0 ? 8'(wd) : 8'h00) : 8'(5 - i);
        s += int'(b);
        exp_q.push_back(b);
      end
    exp_q.push_back(8'(s % 256));
  endtask

  function automatic int cmp_bytes();
    int n;
    n = (got.size() == exp_q.size()) ? 0 : 1000;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic run_frame(input bit bp, input bit inject);
    bit pv, pr;
    logic [7:0] pd;
    int n;
    pv = 0; pr = 1; pd = 8'h00;
    got.delete(); sel_log.delete(); idx_log.delete();
    busy_cnt = 0; done_cnt = 0; stab_err = 0; idx_err = 0; tail_err = 0;
    START = 1'b1; TX_READY = 1'b1;
    @(negedge CLK_50);
    START = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      if (BUSY) busy_cnt++;
      if (DONE) done_cnt++;
      if (pv && !pr && (!TX_VALID || TX_DATA !== pd)) stab_err++;
      if ((SEL == 3'd0 && IDX >= 5'd16) || (SEL == 3'd1 && IDX >= 5'd8)) idx_err++;
      TX_READY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      START = inject && (c == 40 || DONE);
      if (TX_VALID && TX_READY) begin
        n = got.size();
        if (n >= 1 && n <= 131 && (n - 1) % 5 == 0) begin
          sel_log.push_back(int'(SEL));
          idx_log.push_back(int'(IDX));
        end
        got.push_back(TX_DATA);
      end
      pv = TX_VALID; pr = TX_READY; pd = TX_DATA;
      @(negedge CLK_50);
    end
    START = 1'b0; TX_READY = 1'b1;
    repeat (10) begin
      if (BUSY || TX_VALID || DONE) tail_err++;
      @(negedge CLK_50);
    end
  endtask

  initial begin
    int serr, ierr, flag;
    repeat (3) @(negedge CLK_50);
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", TX_VALID, 0);
    chk("rst_sel_idx_data", {SEL, IDX, TX_DATA}, 0);
    RESET = 1'b0;
    flag = 0;
    repeat (20) begin
      if (BUSY || DONE || TX_VALID) flag++;
      @(negedge CLK_50);
    end
    chk("idle_quiet", flag, 0);

    build_exp(0);
    run_frame(0, 0);
    chk("full_bytes", cmp_bytes(), 0);
    chk("full_len", got.size(), 137);
    chk("full_csum", got.size() > 0 ? got[got.size()-1] : 8'hxx, 8'h95);
    chk("full_busy", busy_cnt, 191);
    chk("full_done", done_cnt, 1);
    chk("full_tail", tail_err, 0);

    walk = 1'b1;
    build_exp(1);
    run_frame(0, 0);
    serr = (sel_log.size() == 27) ? 0 : 1000;
    ierr = serr;
    for (int i = 0; i < sel_log.size() && i < 27; i++) begin
      if (sel_log[i] != (i < 16 ? 0 : i < 24 ? 1 : i - 22)) serr++;
      if (idx_log[i] != (i < 16 ? i : i < 24 ? i - 16 : 0)) ierr++;
    end
    chk("walk_bytes", cmp_bytes(), 0);
    chk("walk_csum", got.size() > 0 ? got[got.size()-1] : 8'hxx, 8'h1D);
    chk("walk_sel_seq", serr, 0);
    chk("walk_idx_seq", ierr, 0);
    chk("walk_idx_range", idx_err, 0);
    walk = 1'b0;

    build_exp(0);
    run_frame(1, 0);
    chk("bp_bytes", cmp_bytes(), 0);
    chk("bp_stable", stab_err, 0);
    chk("bp_done", done_cnt, 1);
    chk("bp_tail", tail_err, 0);

    run_frame(0, 1);
    chk("inj_bytes", cmp_bytes(), 0);
    chk("inj_done", done_cnt, 1);
    chk("inj_tail", tail_err, 0);

    got.delete();
    START = 1'b1; TX_READY = 1'b1;
    @(negedge CLK_50);
    START = 1'b0;
    for (int c = 0; c < 500 && !(TX_VALID && got.size() == 29); c++) begin
      if (TX_VALID) got.push_back(TX_DATA);
      @(negedge CLK_50);
    end
    chk("abort_reached", {TX_VALID, 8'(got.size()), TX_DATA}, {1'b1, 8'd29, 8'h02});
    RESET = 1'b1;
    @(negedge CLK_50);
    chk("abort_valid", TX_VALID, 0);
    chk("abort_busy_done", {BUSY, DONE}, 0);
    RESET = 1'b0;
    flag = 0;
    repeat (10) begin
      if (BUSY || DONE || TX_VALID) flag++;
      @(negedge CLK_50);
    end
    chk("abort_quiet", flag, 0);
    run_frame(0, 0);
    chk("after_abort_sof", got.size() > 0 ? got[0] : 8'hxx, 8'hA5);
    chk("after_abort_bytes", cmp_bytes(), 0);
    chk("after_abort_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
